// File: rtl/wifi_tx_ifft_scheduler.sv
// -----------------------------------------------------------------------------
// wifi_tx_ifft_scheduler
//
// Frame-level sequencer for the WiFi TX IFFT controller. A single frame request
// becomes the ordered control sequence the IFFT controller needs:
//   start -> wait for preamble -> per-symbol mapper handshake -> last-symbol
//   marking -> done.
// Symbol boundaries are found by counting IFFT output samples. A watchdog
// flags an error when the IFFT goes quiet for too long in RUN.
//
// Handshake semantics (all single-bit, sampled on the rising clk edge):
//   tx_start/num_symbols : request, accepted only in IDLE, with abort low and
//                          num_symbols != 0. ifft_start answers one cycle later.
//   preamble_done        : level, only looked at in PREAMBLE.
//   mapper_ready         : level, only looked at in WAIT_MAP. map_req answers
//                          one cycle later as a single-cycle pulse.
//   ifft_valid_out       : one strobe per sample, only counted in RUN.
//   abort                : highest priority outside reset; any non-IDLE state
//                          returns to IDLE on the next edge.
//
// Ports:
//   clk, reset (async, active low)
//   tx_start, num_symbols, abort         : MAC-side control
//   preamble_done, mapper_ready,
//   ifft_valid_out                       : IFFT controller / mapper status
//   ifft_start, ifft_last_symbol,
//   map_req, sym_index                   : IFFT controller / mapper control
//   tx_busy, tx_done, tx_error           : status to the AHB-side logic
//   dbg_state                            : current FSM state
//                                          (0 IDLE, 1 PREAMBLE, 2 WAIT_MAP,
//                                           3 RUN, 4 DONE)
// All outputs are registered and reset to 0.
// -----------------------------------------------------------------------------
module wifi_tx_ifft_scheduler #(
  parameter int SYM_SAMPLES = 80,
  parameter int NSYM_W      = 8,
  parameter int TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [NSYM_W-1:0] num_symbols,
  input  logic              abort,
  input  logic              preamble_done,
  input  logic              mapper_ready,
  input  logic              ifft_valid_out,
  output logic              ifft_start,
  output logic              ifft_last_symbol,
  output logic              map_req,
  output logic [NSYM_W-1:0] sym_index,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_error,
  output logic [2:0]        dbg_state
);

  localparam int SMP_W = $clog2(SYM_SAMPLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SYM_SAMPLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_WAIT_MAP = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [NSYM_W-1:0] nsym_q, nsym_d;
  logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              ifft_start_q, ifft_start_d;
  logic              last_q, last_d;
  logic              map_req_q, map_req_d;
  logic [NSYM_W-1:0] sym_index_q, sym_index_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              timeout_hit;

  always_comb begin
    state_d      = state_q;
    nsym_d       = nsym_q;
    smp_cnt_d    = smp_cnt_q;
    to_cnt_d     = to_cnt_q;
    ifft_start_d = 1'b0;
    last_d       = last_q;
    map_req_d    = 1'b0;
    sym_index_d  = sym_index_q;
    done_d       = 1'b0;
    error_d      = error_q;
    timeout_hit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort in IDLE does nothing itself but masks a same-cycle request.
        if (tx_start && !abort && (num_symbols != '0)) begin
          nsym_d       = num_symbols;
          error_d      = 1'b0;
          ifft_start_d = 1'b1;
          state_d      = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (preamble_done) begin
          state_d = S_WAIT_MAP;
        end
      end
      S_WAIT_MAP: begin
        if (mapper_ready) begin
          map_req_d = 1'b1;
          last_d    = (sym_index_q == (nsym_q - NSYM_W'(1)));
          smp_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (ifft_valid_out) begin
          to_cnt_d  = '0;
          smp_cnt_d = smp_cnt_q + SMP_W'(1);
          if (smp_cnt_q == SMP_LAST) begin
            // Symbol boundary: the counter restarts, so it never wraps.
            smp_cnt_d = '0;
            if (last_q) begin
              last_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              sym_index_d = sym_index_q + NSYM_W'(1);
              state_d     = S_WAIT_MAP;
            end
          end
        end else if (to_cnt_q == TO_LAST) begin
          // TIMEOUT consecutive quiet cycles in RUN.
          timeout_hit = 1'b1;
          error_d     = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        sym_index_d = '0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort and timeout share one exit; abort wins and keeps tx_error as is.
    if ((state_q != S_IDLE) && (abort || timeout_hit)) begin
      state_d     = S_IDLE;
      last_d      = 1'b0;
      sym_index_d = '0;
      smp_cnt_d   = '0;
      to_cnt_d    = '0;
      map_req_d   = 1'b0;
      done_d      = 1'b0;
      if (abort) begin
        error_d = error_q;
      end
    end

    // busy stays up through the tx_done cycle that follows DONE.
    busy_d = (state_d != S_IDLE) || ((state_q == S_DONE) && !abort);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      nsym_q       <= '0;
      smp_cnt_q    <= '0;
      to_cnt_q     <= '0;
      ifft_start_q <= 1'b0;
      last_q       <= 1'b0;
      map_req_q    <= 1'b0;
      sym_index_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      nsym_q       <= nsym_d;
      smp_cnt_q    <= smp_cnt_d;
      to_cnt_q     <= to_cnt_d;
      ifft_start_q <= ifft_start_d;
      last_q       <= last_d;
      map_req_q    <= map_req_d;
      sym_index_q  <= sym_index_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign ifft_start       = ifft_start_q;
  assign ifft_last_symbol = last_q;
  assign map_req          = map_req_q;
  assign sym_index        = sym_index_q;
  assign tx_busy          = busy_q;
  assign tx_done          = done_q;
  assign tx_error         = error_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_wifi_tx_ifft_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for wifi_tx_ifft_scheduler. The driver knows the frame it is playing
// and pushes the events the scheduler must produce (start, each mapper
// request, done, return to idle) with the cycle they must appear in. The
// monitor turns DUT output pulses into the same event words and pops/compares.
// -----------------------------------------------------------------------------
module tb_wifi_tx_ifft_scheduler;

  localparam int SYM = 80;
  localparam int TO  = 20;

  localparam logic [2:0] EV_START = 3'd1;
  localparam logic [2:0] EV_MAP   = 3'd2;
  localparam logic [2:0] EV_DONE  = 3'd3;
  localparam logic [2:0] EV_IDLE  = 3'd4;

  localparam int M_NOM         = 0;
  localparam int M_TIMEOUT     = 1;
  localparam int M_ABORT_PRE   = 2;
  localparam int M_ABORT_WAIT  = 3;
  localparam int M_ABORT_RUN   = 4;
  localparam int M_ABORT_FINAL = 5;
  localparam int M_RESET       = 6;

  logic       clk;
  logic       reset;
  logic       tx_start;
  logic [7:0] num_symbols;
  logic       abort;
  logic       preamble_done;
  logic       mapper_ready;
  logic       ifft_valid_out;
  logic       ifft_start;
  logic       ifft_last_symbol;
  logic       map_req;
  logic [7:0] sym_index;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic [2:0] dbg_state;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic        busy_prev;

  wifi_tx_ifft_scheduler #(
    .SYM_SAMPLES(SYM),
    .NSYM_W(8),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_start(tx_start),
    .num_symbols(num_symbols),
    .abort(abort),
    .preamble_done(preamble_done),
    .mapper_ready(mapper_ready),
    .ifft_valid_out(ifft_valid_out),
    .ifft_start(ifft_start),
    .ifft_last_symbol(ifft_last_symbol),
    .map_req(map_req),
    .sym_index(sym_index),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [31:0] ev(input logic [2:0] kind, input logic [7:0] idx,
                                     input logic last, input logic err, input int tag);
    logic [18:0] t;
    t = tag[18:0];
    return {kind, idx, last, err, t};
  endfunction

  function automatic logic rbit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic got(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event %s: got %0h at cycle %0d, expected no event", name, act, cyc);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_bad++;
        $display("FAIL event %s: got kind=%0d idx=%0d last=%0b err=%0b cyc=%0d, expected kind=%0d idx=%0d last=%0b err=%0b cyc=%0d",
                 name, act[31:29], act[28:21], act[20], act[19], act[18:0],
                 e[31:29], e[28:21], e[20], e[19], e[18:0]);
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        busy_prev = 1'b0;
      end else begin
        if (ifft_start) got("start", ev(EV_START, sym_index, ifft_last_symbol, tx_error, cyc));
        if (map_req)    got("map",   ev(EV_MAP,   sym_index, ifft_last_symbol, tx_error, cyc));
        if (tx_done)    got("done",  ev(EV_DONE,  sym_index, ifft_last_symbol, tx_error, cyc));
        if (busy_prev && !tx_busy)
          got("idle", ev(EV_IDLE, sym_index, ifft_last_symbol, tx_error, cyc));
        busy_prev = tx_busy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tx_start       = 1'b0;
    num_symbols    = 8'd0;
    abort          = 1'b0;
    preamble_done  = 1'b0;
    mapper_ready   = 1'b0;
    ifft_valid_out = 1'b0;
  endtask

  task automatic finish_frame();
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic do_abort(input bit clean);
    abort          = 1'b1;
    ifft_valid_out = clean ? 1'b0 : rbit();
    exp_q.push_back(ev(EV_IDLE, 8'd0, 1'b0, 1'b0, cyc + 1));
    tick();
    finish_frame();
  endtask

  task automatic mid_reset();
    idle_inputs();
    #1;
    reset = 1'b0;
    #1;
    chk("rst_ifft_start", {31'd0, ifft_start}, 32'd0);
    chk("rst_last",       {31'd0, ifft_last_symbol}, 32'd0);
    chk("rst_map_req",    {31'd0, map_req}, 32'd0);
    chk("rst_sym_index",  {24'd0, sym_index}, 32'd0);
    chk("rst_busy",       {31'd0, tx_busy}, 32'd0);
    chk("rst_done",       {31'd0, tx_done}, 32'd0);
    chk("rst_error",      {31'd0, tx_error}, 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
  endtask

  // One frame of n symbols. Events are pushed in the cycle whose inputs cause
  // them; a response to inputs driven at cycle k shows up at cycle k+1.
  task automatic run_frame(input int n, input int mode, input int sel,
                           input bit clean, input int stall_fix, input int pre_wait);
    int ns;
    int gap;
    int stall;
    bit is_last;
    bit quiet_sym;
    tx_start    = 1'b1;
    num_symbols = 8'(n);
    abort       = 1'b0;
    exp_q.push_back(ev(EV_START, 8'd0, 1'b0, 1'b0, cyc + 1));
    tick();
    tx_start    = 1'b0;
    num_symbols = 8'd0;
    for (int w = 0; w < pre_wait; w++) begin
      if (!clean) begin
        mapper_ready   = rbit();
        ifft_valid_out = rbit();
      end
      tick();
    end
    mapper_ready   = 1'b0;
    ifft_valid_out = 1'b0;
    if (mode == M_ABORT_PRE) begin
      do_abort(clean);
      return;
    end
    preamble_done = 1'b1;
    tick();
    preamble_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      is_last   = (i == n - 1);
      quiet_sym = (mode == M_TIMEOUT) && (i == sel);
      stall     = (stall_fix >= 0) ? stall_fix : (clean ? 0 : int'($urandom_range(0, 6)));
      if ((mode == M_ABORT_WAIT) && (i == sel) && (stall == 0)) stall = 1;
      for (int s = 0; s < stall; s++) begin
        mapper_ready   = 1'b0;
        ifft_valid_out = clean ? 1'b0 : rbit();
        tick();
      end
      ifft_valid_out = 1'b0;
      if ((mode == M_ABORT_WAIT) && (i == sel)) begin
        do_abort(clean);
        return;
      end
      mapper_ready = 1'b1;
      exp_q.push_back(ev(EV_MAP, 8'(i), is_last, 1'b0, cyc + 1));
      tick();
      mapper_ready = 1'b0;
      ns  = 0;
      gap = 0;
      while (ns < SYM) begin
        if (!clean) begin
          mapper_ready  = rbit();
          preamble_done = rbit();
          tx_start      = ($urandom_range(0, 7) == 0);
          num_symbols   = 8'($urandom_range(0, 255));
        end
        if (quiet_sym && (ns == 30)) begin
          ifft_valid_out = 1'b0;
          exp_q.push_back(ev(EV_IDLE, 8'd0, 1'b0, 1'b1, cyc + TO));
          repeat (TO) tick();
          finish_frame();
          return;
        end
        if ((mode == M_ABORT_RUN) && (i == sel) && (ns == 40)) begin
          do_abort(clean);
          return;
        end
        if ((mode == M_RESET) && (i == sel) && (ns == 40)) begin
          mid_reset();
          return;
        end
        if (!clean && !quiet_sym && (gap < 4) && ($urandom_range(0, 3) == 0)) begin
          ifft_valid_out = 1'b0;
          gap++;
        end else begin
          ifft_valid_out = 1'b1;
          gap = 0;
          ns++;
        end
        if (ifft_valid_out && (ns == SYM) && is_last) begin
          if (mode == M_ABORT_FINAL) begin
            abort = 1'b1;
            exp_q.push_back(ev(EV_IDLE, 8'd0, 1'b0, 1'b0, cyc + 1));
            tick();
            finish_frame();
            return;
          end
          exp_q.push_back(ev(EV_DONE, 8'd0, 1'b0, 1'b0, cyc + 2));
          exp_q.push_back(ev(EV_IDLE, 8'd0, 1'b0, 1'b0, cyc + 3));
        end
        tick();
      end
    end
    finish_frame();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int mode;
    idle_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset_ifft_start", {31'd0, ifft_start}, 32'd0);
    chk("reset_last",       {31'd0, ifft_last_symbol}, 32'd0);
    chk("reset_map_req",    {31'd0, map_req}, 32'd0);
    chk("reset_sym_index",  {24'd0, sym_index}, 32'd0);
    chk("reset_busy",       {31'd0, tx_busy}, 32'd0);
    chk("reset_done",       {31'd0, tx_done}, 32'd0);
    chk("reset_error",      {31'd0, tx_error}, 32'd0);
    chk("reset_state",      {29'd0, dbg_state}, 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Nominal: 3 symbols, preamble 10 cycles after start, mapper always ready.
    run_frame(3, M_NOM, 0, 1'b1, 0, 10);
    // Mapper stall of 50 cycles before every symbol; no timeout in WAIT_MAP.
    run_frame(2, M_NOM, 0, 1'b1, 50, 3);
    // Noisy frame: stray tx_start/preamble_done/mapper_ready in RUN are ignored.
    run_frame(2, M_NOM, 0, 1'b0, -1, 5);

    // Timeout in the second symbol after 30 samples.
    run_frame(3, M_TIMEOUT, 1, 1'b0, -1, 4);
    chk("error_after_timeout", {31'd0, tx_error}, 32'd1);

    // Zero-length request: ignored, tx_error stays set.
    tx_start    = 1'b1;
    num_symbols = 8'd0;
    tick();
    idle_inputs();
    repeat (3) tick();
    chk("zero_req_busy",  {31'd0, tx_busy}, 32'd0);
    chk("zero_req_error", {31'd0, tx_error}, 32'd1);

    // abort together with tx_start in IDLE: request ignored.
    tx_start    = 1'b1;
    num_symbols = 8'd5;
    abort       = 1'b1;
    tick();
    idle_inputs();
    repeat (3) tick();
    chk("idle_abort_busy",  {31'd0, tx_busy}, 32'd0);
    chk("idle_abort_error", {31'd0, tx_error}, 32'd1);

    // Next accepted start clears tx_error (START event expects err=0).
    run_frame(1, M_NOM, 0, 1'b0, -1, 2);

    // Abort coinciding with the last sample of the last symbol.
    run_frame(2, M_ABORT_FINAL, 0, 1'b0, -1, 2);
    run_frame(3, M_ABORT_PRE, 0, 1'b0, -1, 6);
    run_frame(3, M_ABORT_WAIT, 1, 1'b0, -1, 2);
    run_frame(3, M_ABORT_RUN, 2, 1'b0, -1, 2);

    // Async reset in the middle of RUN, then a fresh nominal frame.
    run_frame(3, M_RESET, 1, 1'b0, -1, 3);
    run_frame(3, M_NOM, 0, 1'b1, 0, 10);

    // Largest frame: sym_index walks 0..254.
    run_frame(255, M_NOM, 0, 1'b1, 0, 1);

    // Randomised frames.
    for (int r = 0; r < 14; r++) begin
      n    = $urandom_range(1, 4);
      mode = $urandom_range(0, 6);
      if (mode == M_RESET) mode = M_NOM;
      run_frame(n, mode, $urandom_range(0, n - 1), 1'b0, -1, $urandom_range(1, 25));
    end

    idle_inputs();
    repeat (5) tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d still outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
